// File: rtl/uc1611_pkg.sv
// Shared types and constants for the UC1611 grayscale LCD stream driver.
// Holds the controller state enum, the FIFO word layout and the init command ROM.
package uc1611_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAIT,
        ST_INIT,
        ST_ON,
        ST_UNINIT
    } state_t;

    typedef struct packed {
        logic       cd;
        logic [7:0] data;
    } lcd_word_t;

    localparam logic [7:0] CMD_SYS_RESET = 8'he2;
    localparam logic [3:0] REWIND_IDX    = 4'd12;
    localparam logic [3:0] ROM_LAST      = 4'd15;

    function automatic logic [7:0] gray_cmd(input int bpp);
        return (bpp == 2) ? 8'hd1 : 8'hd2;
    endfunction

    // Evenly spread gray levels for the four Game Boy shades.
    function automatic logic [3:0] default_pal(input int bpp,
                                               input logic [1:0] idx);
        if (bpp == 2)
            return {2'b00, idx};
        return 4'({2'b00, idx} * 4'd5);
    endfunction

    // Entries 12..15 set page/column to zero and double as the frame rewind.
    function automatic logic [7:0] init_rom(input logic [3:0] idx,
                                            input logic [7:0] map_cmd,
                                            input logic [7:0] rate_cmd,
                                            input logic [7:0] gray);
        logic [7:0] v;
        v = 8'h00;
        case (idx)
            4'd0:  v = map_cmd;
            4'd1:  v = rate_cmd;
            4'd2:  v = 8'h2a;
            4'd3:  v = gray;
            4'd4:  v = 8'hea;
            4'd5:  v = 8'h81;
            4'd6:  v = 8'h00;
            4'd7:  v = 8'h84;
            4'd8:  v = 8'h8b;
            4'd9:  v = 8'haf;
            4'd10: v = 8'h40;
            4'd11: v = 8'h50;
            4'd12: v = 8'h60;
            4'd13: v = 8'h70;
            4'd14: v = 8'h00;
            default: v = 8'h10;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/uc1611_fifo.sv
// Synchronous FIFO for {cd,data} LCD words with flush.
// Ports: clk, reset, flush, push/wdata, pop/rdata, full, empty.
module uc1611_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_pop;
    logic          do_push;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot the same cycle, so a push into a full FIFO
    // is still taken when a pop accompanies it.
    assign do_push = push && (!full || do_pop);
    // A flush with a push leaves exactly that one word queued.
    assign wr_en   = flush ? push : do_push;
    assign wr_addr = flush ? '0 : wptr;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= push ? AW'(1) : '0;
            cnt  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uc1611_stream.sv
// UC1611 LCD driver: power-up wait, init commands, frame rewind and pixel packing.
// Ports: clk/reset, PPU side (disp_on, hsync, vsync, px_out, px), palette write, LCD bus, ovf.
module uc1611_stream
    import uc1611_pkg::*;
#(
    parameter int         BPP        = 4,
    parameter int         WAIT_BITS  = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter int         WR_CYCLES  = 1,
    parameter logic [7:0] MAP_CMD    = 8'hc6,
    parameter logic [7:0] RATE_CMD   = 8'ha1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           disp_on,
    input  logic           hsync,
    input  logic           vsync,
    input  logic           px_out,
    input  logic [1:0]     px,
    input  logic           pal_we,
    input  logic [1:0]     pal_idx,
    input  logic [BPP-1:0] pal_val,
    output logic [7:0]     lcd_data,
    output logic           lcd_read,
    output logic           lcd_write,
    input  logic           lcd_reset,
    output logic           lcd_cs,
    output logic           lcd_cd,
    output logic           lcd_vled,
    output logic           ovf
);

    localparam int         PPB  = 8 / BPP;
    localparam logic [7:0] GRAY = gray_cmd(BPP);

    state_t               state;
    state_t               state_nx;
    logic [WAIT_BITS-1:0] count;
    logic [3:0]           rom_idx;
    logic                 insync;
    logic [BPP-1:0]       pal [4];
    logic [7:0]           pack;
    logic [7:0]           pack_nx;
    logic [7:0]           pix_ext;
    logic [1:0]           pcnt;
    logic                 byte_done;
    logic                 pack_en;

    logic                 busy;
    logic [4:0]           wr_cnt;
    logic                 seq_last;
    logic                 pop_fire;

    logic                 push;
    logic                 push_ok;
    logic                 flush;
    lcd_word_t            push_word;
    lcd_word_t            head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 lcd_reset_unused;

    assign lcd_read         = 1'b0;
    assign lcd_cs           = 1'b1;
    assign lcd_vled         = disp_on;
    assign lcd_reset_unused = lcd_reset;

    // Pixels fill the byte from the LSB upwards.
    assign pix_ext   = 8'(pal[px]);
    assign pack_nx   = pack | (pix_ext << (BPP * int'(pcnt)));
    assign byte_done = (pcnt == 2'(PPB - 1));
    assign pack_en   = (state == ST_ON) && disp_on && insync
                       && px_out && !vsync;

    assign seq_last  = busy && (wr_cnt == 5'(2 * WR_CYCLES - 1));
    // Never launch a word out of a FIFO that is being flushed.
    assign pop_fire  = !fifo_empty && !flush && (!busy || seq_last);
    assign push_ok   = !fifo_full || pop_fire;

    uc1611_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (9)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (push_word),
        .pop   (pop_fire),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_word = '0;
        flush     = 1'b0;
        unique case (state)
            ST_OFF: begin
                if (disp_on)
                    state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!disp_on) begin
                    flush    = 1'b1;
                    state_nx = ST_OFF;
                end else if (count[WAIT_BITS-1 -: 2] == 2'b11) begin
                    state_nx = ST_INIT;
                end
            end
            ST_INIT: begin
                if (!disp_on) begin
                    flush    = 1'b1;
                    state_nx = ST_OFF;
                end else begin
                    push      = 1'b1;
                    push_word = {1'b0, init_rom(rom_idx, MAP_CMD,
                                                RATE_CMD, GRAY)};
                    if (push_ok && rom_idx == ROM_LAST)
                        state_nx = ST_ON;
                end
            end
            ST_ON: begin
                if (!disp_on) begin
                    flush     = 1'b1;
                    push      = 1'b1;
                    push_word = {1'b0, CMD_SYS_RESET};
                    state_nx  = ST_UNINIT;
                end else if (vsync) begin
                    state_nx = ST_INIT;
                end else if (pack_en && byte_done) begin
                    push      = 1'b1;
                    push_word = {1'b1, pack_nx};
                end
            end
            ST_UNINIT: begin
                if (fifo_empty && !busy)
                    state_nx = ST_OFF;
            end
            default: state_nx = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_OFF;
            count   <= '0;
            rom_idx <= '0;
            insync  <= 1'b0;
            pack    <= '0;
            pcnt    <= '0;
            ovf     <= 1'b0;
            for (int i = 0; i < 4; i++)
                pal[i] <= BPP'(default_pal(BPP, 2'(i)));
        end else begin
            state <= state_nx;

            if (pal_we)
                pal[pal_idx] <= pal_val;

            if (state == ST_OFF && disp_on)
                insync <= 1'b1;
            else if (vsync)
                insync <= 1'b1;
            else if (state != ST_ON && (hsync || px_out))
                insync <= 1'b0;

            if (state == ST_OFF)
                count <= '0;
            else if (state == ST_WAIT)
                count <= count + WAIT_BITS'(1);

            if (state == ST_WAIT)
                rom_idx <= '0;
            else if (state == ST_INIT && disp_on && push_ok)
                rom_idx <= rom_idx + 4'd1;
            else if (state == ST_ON && disp_on && vsync)
                rom_idx <= REWIND_IDX;

            // A partial byte never survives leaving ON or a new frame.
            if (state != ST_ON || vsync) begin
                pack <= '0;
                pcnt <= '0;
            end else if (pack_en) begin
                if (byte_done) begin
                    pack <= '0;
                    pcnt <= '0;
                end else begin
                    pack <= pack_nx;
                    pcnt <= pcnt + 2'd1;
                end
            end

            if (state == ST_ON && disp_on && vsync)
                ovf <= 1'b0;
            else if (state == ST_ON && push && push_word.cd && !push_ok)
                ovf <= 1'b1;
        end
    end

    // Strobe sequencer: WR_CYCLES high, then WR_CYCLES low per word.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            wr_cnt    <= '0;
            lcd_write <= 1'b0;
            lcd_data  <= '0;
            lcd_cd    <= 1'b0;
        end else if (pop_fire) begin
            busy      <= 1'b1;
            wr_cnt    <= '0;
            lcd_write <= 1'b1;
            lcd_data  <= head.data;
            lcd_cd    <= head.cd;
        end else if (busy) begin
            wr_cnt <= wr_cnt + 5'd1;
            if (wr_cnt == 5'(WR_CYCLES - 1))
                lcd_write <= 1'b0;
            if (seq_last)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uc1611_stream.sv
// Directed bench for uc1611_stream: three configurations driven in lockstep.
// a: BPP4/WR1, b: BPP2/WR1, c: BPP4/WR3; every strobe is logged per instance.
module tb_uc1611_stream;

    logic       clk;
    logic       reset;
    logic       disp_on;
    logic       hsync;
    logic       vsync;
    logic       px_out;
    logic [1:0] px;
    logic       pal_we;
    logic [1:0] pal_idx;
    logic [3:0] pal_val;
    logic [1:0] pal_val_b;
    logic       lcd_rst;

    logic [7:0] a_data, b_data, c_data;
    logic       a_read, b_read, c_read;
    logic       a_write, b_write, c_write;
    logic       a_cs, b_cs, c_cs;
    logic       a_cd, b_cd, c_cd;
    logic       a_vled, b_vled, c_vled;
    logic       a_ovf, b_ovf, c_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] mq [3][$];
    logic [2:0] wr_q = 3'b000;

    logic [7:0] rom_a [16] = '{8'hc6, 8'ha1, 8'h2a, 8'hd2,
                               8'hea, 8'h81, 8'h00, 8'h84,
                               8'h8b, 8'haf, 8'h40, 8'h50,
                               8'h60, 8'h70, 8'h00, 8'h10};
    logic [8:0] rew [4] = '{9'h060, 9'h070, 9'h000, 9'h010};

    uc1611_stream #(.BPP(4), .WAIT_BITS(4), .FIFO_DEPTH(4),
                    .WR_CYCLES(1)) ua (
        .clk(clk), .reset(reset), .disp_on(disp_on), .hsync(hsync),
        .vsync(vsync), .px_out(px_out), .px(px), .pal_we(pal_we),
        .pal_idx(pal_idx), .pal_val(pal_val), .lcd_data(a_data),
        .lcd_read(a_read), .lcd_write(a_write), .lcd_reset(lcd_rst),
        .lcd_cs(a_cs), .lcd_cd(a_cd), .lcd_vled(a_vled), .ovf(a_ovf));

    uc1611_stream #(.BPP(2), .WAIT_BITS(4), .FIFO_DEPTH(4),
                    .WR_CYCLES(1)) ub (
        .clk(clk), .reset(reset), .disp_on(disp_on), .hsync(hsync),
        .vsync(vsync), .px_out(px_out), .px(px), .pal_we(pal_we),
        .pal_idx(pal_idx), .pal_val(pal_val_b), .lcd_data(b_data),
        .lcd_read(b_read), .lcd_write(b_write), .lcd_reset(lcd_rst),
        .lcd_cs(b_cs), .lcd_cd(b_cd), .lcd_vled(b_vled), .ovf(b_ovf));

    uc1611_stream #(.BPP(4), .WAIT_BITS(4), .FIFO_DEPTH(4),
                    .WR_CYCLES(3)) uc (
        .clk(clk), .reset(reset), .disp_on(disp_on), .hsync(hsync),
        .vsync(vsync), .px_out(px_out), .px(px), .pal_we(pal_we),
        .pal_idx(pal_idx), .pal_val(pal_val), .lcd_data(c_data),
        .lcd_read(c_read), .lcd_write(c_write), .lcd_reset(lcd_rst),
        .lcd_cs(c_cs), .lcd_cd(c_cd), .lcd_vled(c_vled), .ovf(c_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log {cd,data} at every rising lcd_write.
    always @(negedge clk) begin
        if (a_write && !wr_q[0]) mq[0].push_back({a_cd, a_data});
        if (b_write && !wr_q[1]) mq[1].push_back({b_cd, b_data});
        if (c_write && !wr_q[2]) mq[2].push_back({c_cd, c_data});
        wr_q <= {c_write, b_write, a_write};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_px(input logic [1:0] v);
        px     = v;
        px_out = 1'b1;
        tick();
        px_out = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic clr();
        for (int k = 0; k < 3; k++)
            mq[k].delete();
    endtask

    function automatic logic [8:0] qent(input int k, input int j);
        if (j < mq[k].size())
            return mq[k][j];
        return 9'h1ff;
    endfunction

    function automatic int ndata(input int k);
        int n = 0;
        for (int j = 0; j < mq[k].size(); j++)
            if (mq[k][j][8]) n++;
        return n;
    endfunction

    function automatic logic [8:0] data_n(input int k, input int n);
        int c = 0;
        for (int j = 0; j < mq[k].size(); j++) begin
            if (mq[k][j][8]) begin
                if (c == n) return mq[k][j];
                c++;
            end
        end
        return 9'h1ff;
    endfunction

    initial begin
        int cyc;
        reset = 1'b1; disp_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
        px_out = 1'b0; px = 2'd0; pal_we = 1'b0; pal_idx = 2'd0;
        pal_val = 4'd0; pal_val_b = 2'd0; lcd_rst = 1'b1;
        tick(3);

        chk("rst_write", 32'(a_write), 32'h0);
        chk("rst_data", 32'(a_data), 32'h0);
        chk("rst_cd", 32'(a_cd), 32'h0);
        chk("rst_ovf", 32'(a_ovf), 32'h0);
        chk("rst_read", 32'(a_read), 32'h0);
        chk("rst_cs", 32'(a_cs), 32'h1);

        // OFF->WAIT, 12 counts, detect, push, pop: rise on edge 16.
        reset = 1'b0;
        disp_on = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!a_write && cyc < 100);
        chk("first_strobe_cyc", 32'(cyc), 32'd16);

        tick(150);
        chk("init_a_len", 32'(mq[0].size()), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("init_a_%0d", i), 32'(qent(0, i)),
                32'({1'b0, rom_a[i]}));
        chk("init_b_len", 32'(mq[1].size()), 32'd16);
        chk("init_b_gray", 32'(qent(1, 3)), 32'h0d1);
        chk("init_c_len", 32'(mq[2].size()), 32'd16);

        // Frame: rewind then px 0,1,2,3.
        clr();
        pulse_vsync();
        tick(10);
        send_px(2'd0); send_px(2'd1); send_px(2'd2); send_px(2'd3);
        tick(20);
        chk("frm_a_len", 32'(mq[0].size()), 32'd6);
        for (int i = 0; i < 4; i++)
            chk($sformatf("frm_a_rew%0d", i), 32'(qent(0, i)), 32'(rew[i]));
        chk("frm_a_d0", 32'(qent(0, 4)), 32'h150);
        chk("frm_a_d1", 32'(qent(0, 5)), 32'h1fa);
        chk("frm_b_len", 32'(mq[1].size()), 32'd5);
        chk("frm_b_d0", 32'(qent(1, 4)), 32'h1e4);

        // Palette entry 1 -> 9.
        clr();
        pal_we = 1'b1; pal_idx = 2'd1; pal_val = 4'd9; pal_val_b = 2'd2;
        tick();
        pal_we = 1'b0;
        send_px(2'd1); send_px(2'd1);
        tick(10);
        chk("pal_a_n", 32'(ndata(0)), 32'd1);
        chk("pal_a_d", 32'(data_n(0, 0)), 32'h199);

        // Burst of 16 px into the slow instance overflows its FIFO.
        tick(30);
        for (int i = 0; i < 16; i++)
            send_px(2'(i));
        tick(80);
        chk("ovf_c_set", 32'(c_ovf), 32'h1);
        chk("ovf_a_clr", 32'(a_ovf), 32'h0);
        clr();
        pulse_vsync();
        tick(40);
        chk("ovf_c_vs", 32'(c_ovf), 32'h0);
        chk("rew_c_len", 32'(mq[2].size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rew_c_%0d", i), 32'(qent(2, i)), 32'(rew[i]));

        // disp_on falls with bytes queued: only 'he2 follows.
        pulse_vsync();
        tick(30);
        for (int i = 0; i < 8; i++)
            send_px(2'(i));
        tick();
        disp_on = 1'b0;
        tick();
        clr();
        tick(40);
        chk("off_a_len", 32'(mq[0].size()), 32'd1);
        chk("off_a_e2", 32'(qent(0, 0)), 32'h0e2);
        chk("off_c_len", 32'(mq[2].size()), 32'd1);
        chk("off_c_e2", 32'(qent(2, 0)), 32'h0e2);
        chk("off_vled", 32'(a_vled), 32'h0);

        // Join mid-frame: hsync during WAIT, pixels skipped until vsync.
        clr();
        disp_on = 1'b1;
        tick(3);
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        tick(150);
        chk("mid_init_len", 32'(mq[0].size()), 32'd16);
        chk("mid_init_gray", 32'(qent(0, 3)), 32'h0d2);
        send_px(2'd0); send_px(2'd1); send_px(2'd2); send_px(2'd3);
        tick(20);
        chk("mid_skip_n", 32'(ndata(0)), 32'd0);
        pulse_vsync();
        tick(30);
        clr();
        send_px(2'd2); send_px(2'd3);
        tick(10);
        chk("mid_vs_n", 32'(ndata(0)), 32'd1);
        chk("mid_vs_d", 32'(data_n(0, 0)), 32'h1fa);

        // Reset during a strobe, then default palette again.
        tick(10);
        send_px(2'd0); send_px(2'd0);
        cyc = 0;
        while (!c_write && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rs_strobe_seen", 32'(c_write), 32'h1);
        reset = 1'b1;
        tick();
        chk("rs_write", 32'(c_write), 32'h0);
        chk("rs_data", 32'(c_data), 32'h0);
        chk("rs_cd", 32'(c_cd), 32'h0);
        reset = 1'b0;
        tick(150);
        clr();
        send_px(2'd1); send_px(2'd1);
        tick(20);
        chk("rs_pal_a_n", 32'(ndata(0)), 32'd1);
        chk("rs_pal_a_d", 32'(data_n(0, 0)), 32'h155);
        chk("rs_pal_c_d", 32'(data_n(2, 0)), 32'h155);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
